// File: rtl/window_shift_buffer.sv
// N x N sliding-window generator over a raster pixel stream.
// Keeps N-1 previous rows in circular line buffers addressed by the column
// counter and flags each window that lies entirely inside the image.
module window_shift_buffer #(
  parameter int unsigned bits = 8,
  parameter int unsigned N    = 3,
  parameter int unsigned W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  sof,
  input  logic [bits-1:0]       in,
  output logic [bits*N*N-1:0]   window,
  output logic                  out_valid
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RW = (N > 2) ? $clog2(N) : 1;

  localparam logic [CW-1:0] ColLast  = CW'(W - 1);
  localparam logic [CW-1:0] ColFirst = CW'(N - 1);
  localparam logic [RW-1:0] RowLast  = RW'(N - 1);

  logic [CW-1:0]        col_q, col_d, cur_col;
  logic [RW-1:0]        row_q, row_d, cur_row;
  logic [bits*N*N-1:0]  win_q, win_d;
  logic                 valid_q, valid_d;

  // Line buffer k holds the row k+1 lines above the incoming pixel.
  logic [bits-1:0] lb [N-1][W];

  // Column of pixels entering the window, index = window row (0 is top).
  logic [bits-1:0] col_data [N];

  // Effective position of the current pixel; sof restarts the frame.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Gather the new window column: in at the bottom, oldest line at the top.
  always_comb begin
    for (int r = 0; r < int'(N) - 1; r++) begin
      col_data[r] = lb[int'(N) - 2 - r][cur_col];
    end
    col_data[N-1] = in;
  end

  // Next-state for counters, window and valid flag.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (in_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? cur_row : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      for (int r = 0; r < int'(N); r++) begin
        for (int c = 0; c < int'(N) - 1; c++) begin
          win_d[bits*(r*int'(N)+c) +: bits] = win_q[bits*(r*int'(N)+c+1) +: bits];
        end
        win_d[bits*(r*int'(N)+int'(N)-1) +: bits] = col_data[r];
      end
      // Only windows whose left edge is in the same line are complete.
      valid_d = (cur_row == RowLast) && (cur_col >= ColFirst);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  // Line-buffer cascade; reads above see pre-update contents.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb[0][cur_col] <= in;
      for (int k = 1; k < int'(N) - 1; k++) begin
        lb[k][cur_col] <= lb[k-1][cur_col];
      end
    end
  end

  assign window    = win_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_window_shift_buffer.sv
// Directed bench for window_shift_buffer with N=3, W=4, bits=8.
module tb_window_shift_buffer;

  localparam int unsigned BITS = 8;
  localparam int unsigned NN   = 3;
  localparam int unsigned WW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              sof;
  logic [BITS-1:0]   din;
  logic [BITS*NN*NN-1:0] window;
  logic              out_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  logic [71:0] exp_win;
  bit          exp_known;

  window_shift_buffer #(
    .bits (BITS),
    .N    (NN),
    .W    (WW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sof       (sof),
    .in        (din),
    .window    (window),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window for a qualifying pixel at raster index idx of a frame.
  function automatic logic [71:0] win_model(input int idx, input int base);
    logic [71:0] w;
    int rr, cc;
    rr = idx / 4;
    cc = idx % 4;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[8*(r*3+c) +: 8] = 8'(base + (rr - 2 + r) * 4 + (cc - 2 + c));
      end
    end
    return w;
  endfunction

  task automatic push(input int idx, input int base, input bit s);
    bit ev;
    @(negedge clk);
    in_valid = 1'b1;
    sof      = s;
    din      = 8'(base + idx);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
    ev = (idx / 4 >= 2) && (idx % 4 >= 2);
    check_eq($sformatf("ov_px%0d", base + idx), {71'd0, out_valid}, {71'd0, ev});
    if (ev) begin
      exp_win   = win_model(idx, base);
      exp_known = 1'b1;
      check_eq($sformatf("win_px%0d", base + idx), window, exp_win);
    end else begin
      exp_known = 1'b0;
    end
    if (out_valid) pulses++;
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sof      = s;
      @(posedge clk);
      #1;
      sof = 1'b0;
      check_eq("ov_idle", {71'd0, out_valid}, 72'd0);
      if (exp_known) check_eq("win_hold", window, exp_win);
      if (out_valid) pulses++;
    end
  endtask

  localparam logic [71:0] LastWin =
    {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
  localparam logic [71:0] SofWin =
    {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

  initial begin
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; din = '0;
    exp_known = 1'b0; exp_win = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_win", window, 72'd0);
    check_eq("reset_ov", {71'd0, out_valid}, 72'd0);
    rst = 1'b0;

    // Full frame, continuous valid.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push(i, 0, i == 0);
      if (i == 10) begin
        check_eq("first_w0", {64'd0, window[7:0]}, 72'd0);
        check_eq("first_w8", {64'd0, window[71:64]}, 72'd10);
      end
      if (i == 12 || i == 13) check_eq("line_gate", {71'd0, out_valid}, 72'd0);
    end
    check_eq("last_win", window, LastWin);
    check_eq("pulses_full", 72'(pulses), 72'd4);
    idle(1, 1'b0);

    // Alternate stalls plus a 5-cycle gap after pixel 10.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push(i, 0, i == 0);
      idle((i == 10) ? 5 : 1, 1'b0);
    end
    check_eq("last_win_stall", window, LastWin);
    check_eq("pulses_stall", 72'(pulses), 72'd4);

    // sof without valid mid-frame is ignored.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push(i, 0, i == 0);
      if (i == 6 || i == 11) idle(1, 1'b1);
    end
    check_eq("last_win_sofnv", window, LastWin);
    check_eq("pulses_sofnv", 72'(pulses), 72'd4);

    // Mid-frame sof after pixel 9 starts a new frame 100..115.
    for (int i = 0; i < 10; i++) push(i, 0, i == 0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push(i, 100, i == 0);
      if (i == 9) check_eq("pulses_before_110", 72'(pulses), 72'd0);
      if (i == 10) check_eq("sof_win", window, SofWin);
    end
    check_eq("pulses_midsof", 72'(pulses), 72'd4);

    // Reset coincident with a valid pixel, then a clean frame.
    for (int i = 0; i < 11; i++) push(i, 0, i == 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; din = 8'd11;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_known = 1'b0;
    check_eq("rst_win", window, 72'd0);
    check_eq("rst_ov", {71'd0, out_valid}, 72'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) push(i, 0, i == 0);
    check_eq("last_win_rst", window, LastWin);
    check_eq("pulses_rst", 72'(pulses), 72'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_shift_buffer.md
# window_shift_buffer

Parametrised N×N sliding-window generator for the masked 2D filter kernel. It accepts a raster-order pixel stream with a valid qualifier, keeps the previous N-1 image rows in circular line buffers, and presents a full N×N neighbourhood each time a pixel completes a window lying entirely inside the image. It replaces the fixed single-row shift register at the front of the kernel: it adds 2D windowing, stall tolerance, frame restart and a window-valid flag.

## Interface
- `bits`, 8, pixel width
- `N`, 3, window edge (N ≥ 2); window holds N*N pixels
- `W`, 64, image line width in pixels (W ≥ N)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  `in` carries a pixel this cycle
- `sof`  in  1  start of frame; sampled only when `in_valid`=1
- `in`  in  bits  pixel, raster order (left→right, top→bottom)
- `window`  out  bits*N*N  registered window; element (r,c) at `window[bits*(r*N+c) +: bits]`; r=0 is the oldest (top) row, c=0 is the oldest (left) column
- `out_valid`  out  1  `window` is a complete in-image window; one-cycle pulse per qualifying accepted pixel

## Operation
- State:
  - column counter `col`, 0..W-1;
  - row counter `row`, saturating at N-1;
  - N-1 line buffers `lb[0..N-2]`, each W×bits, addressed by `col`;
  - N×N window register.
- Accepted pixel means `in_valid`=1. With `in_valid`=0, all state and outputs hold, except that `out_valid` drops to 0.
- On an accepted pixel at column c:
  - New window column, bottom to top: `in`, `lb[0][c]`, …, `lb[N-2][c]`. Top row is r=0 and takes `lb[N-2][c]`; bottom row is r=N-1 and takes `in`.
  - Window shifts one column left. Column c=0 is discarded and the new column enters at c=N-1.
  - `lb[0][c]` ← `in`; `lb[k][c]` ← old `lb[k-1][c]` for k=1..N-2. Reads use pre-update values.
  - `col` increments. At W-1 it wraps to 0 and `row` increments, saturating at N-1.
- Window qualification: `out_valid` (next cycle) = 1 iff the accepted pixel had `row` = N-1 and `col` ≥ N-1, both evaluated before the increment. Windows straddling a line boundary are never flagged.
- `sof` with `in_valid`:
  - The pixel is treated as (row 0, col 0), i.e. the counters act as if already reset before the update.
  - Line buffers are not cleared; stale contents never reach a flagged window.
  - `sof` mid-line or mid-frame aborts the current frame.
- `sof` without `in_valid`: ignored.
- Reset:
  - `window` = 0, `out_valid` = 0, `col` = 0, `row` = 0.
  - Line-buffer contents are unspecified after reset. Any RAM or register inference is allowed; no reset of the memories is required.
- Reset has priority over `in_valid` in the same cycle.
- Arithmetic:
  - `col` width is clog2(W), with explicit compare-and-wrap at W-1 (W need not be a power of two).
  - `row` width is clog2(N), or 1 bit minimum.

## Timing
- Latency: `window` and `out_valid` update on the clock edge that accepts the pixel, i.e. visible one cycle after `in_valid`/`in` are presented.
- Throughput: one pixel per cycle sustained. No backpressure output; upstream may stall arbitrarily via `in_valid`.
- Back-to-back qualifying pixels give `out_valid` high on consecutive cycles.
- Line-buffer read and write of the same address in one cycle must return the old data (read-before-write).
- First flagged window of a frame follows the pixel at (N-1, N-1): after N*W-(W-N+1)... precisely (N-1)*W+N accepted pixels.

## Test plan
All scenarios use N=3, W=4, bits=8, pixel value = raster index.
- **Full frame.** Reset, then 16 pixels 0..15 with `sof` on pixel 0 and `in_valid` continuous. Required:
  - exactly 4 `out_valid` pulses, on the cycles after pixels 10, 11, 14, 15;
  - first window r0 = {0,1,2}, r1 = {4,5,6}, r2 = {8,9,10}, i.e. `window[7:0]`=0 and `window[71:64]`=10;
  - last window {5,6,7 / 9,10,11 / 13,14,15}.
- **Stalls.** Same frame with `in_valid` low on alternate cycles plus a 5-cycle gap after pixel 10. Required: identical window sequence; `out_valid` high only on cycles after accepted pixels 10, 11, 14, 15; `window` holds during the gaps.
- **Line-boundary gating.** Pixels 12 and 13 (row 3, col 0/1) accepted. Required: `out_valid`=0 after each; no window mixes columns 3 and 0.
- **Mid-frame sof.** After pixel 9, assert `sof` with a new frame of values 100..115. Required:
  - no `out_valid` until new-frame pixel 110;
  - that window is {100,101,102 / 104,105,106 / 108,109,110}.
- **Reset mid-operation.** Assert `rst` for 1 cycle together with `in_valid` at pixel 11. Required:
  - next cycle `window`=0 and `out_valid`=0;
  - a subsequent frame with `sof` reproduces the full-frame results.
- **Sof without valid.** Pulse `sof` with `in_valid`=0 mid-frame. Required: ignored; window sequence unchanged.
